// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Initiator side of the instruction-memory read interface. Owns the program
//   counter, drives word addresses to a combinational instruction memory and
//   captures every returned word, together with the address it came from,
//   into a small prefetch FIFO. The FIFO head is offered to decode over a
//   valid/ready handshake. Redirects (branch/jump) flush the FIFO and restart
//   fetch; misaligned or out-of-range fetch addresses raise a sticky fault
//   that blocks further fetching until the next redirect or reset.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   MEM_WORDS   number of 32-bit words in instruction memory
//   FIFO_DEPTH  prefetch buffer entries (power of two, at least 2)
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   fetch_en        permits new fetches when high
//   mem_addr        byte address to instruction memory (always the fetch PC)
//   mem_data        word returned by memory in the same cycle as mem_addr
//   instr_valid     FIFO head holds an instruction
//   instr_ready     consumer accepts the head
//   instr           instruction word at the FIFO head
//   instr_pc        byte address the head was fetched from
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address
//   fault           sticky, fetch blocked on an illegal PC
//   level           current FIFO occupancy
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          MEM_WORDS  = 16,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               fetch_en,
   output logic [31:0]                        mem_addr,
   input  logic [31:0]                        mem_data,
   output logic                               instr_valid,
   input  logic                               instr_ready,
   output logic [31:0]                        instr,
   output logic [31:0]                        instr_pc,
   input  logic                               redirect_valid,
   input  logic [31:0]                        redirect_pc,
   output logic                               fault,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   // First byte address past the end of instruction memory.
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] ONE_LEVEL  = LVL_W'(1);
   localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0]      fetchPc;
   logic             faultReg;
   logic [LVL_W-1:0] count;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [31:0]      pcBuf   [FIFO_DEPTH];
   logic [31:0]      dataBuf [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------------
   logic fifoFull;
   logic headPop;
   logic fetchOk;
   logic pcIllegal;
   logic pushEn;
   logic popEn;
   logic faultSet;

   // Decide what happens at the coming edge. A fetch is allowed whenever the
   // FIFO has room now or will have room because the head leaves this cycle,
   // which is what gives one instruction per cycle while the FIFO is full.
   // A redirect voids both the push and the pop: the whole FIFO is discarded
   // anyway, so the consumer must ignore any handshake in that cycle.
   always_comb begin
      fifoFull  = (count == FULL_LEVEL);
      headPop   = instr_valid && instr_ready;
      fetchOk   = fetch_en && !faultReg && (!fifoFull || headPop);
      pcIllegal = (fetchPc[1:0] != 2'b00) || (fetchPc >= MEM_BYTES);
      pushEn    = !redirect_valid && fetchOk && !pcIllegal;
      popEn     = !redirect_valid && headPop;
      faultSet  = !redirect_valid && fetchOk && pcIllegal;
   end

   // ------------------------------------------------------------------------
   // Program counter and sticky fault
   // ------------------------------------------------------------------------

   // The PC only moves on a successful push (by one word, wrapping modulo
   // 2^32) or on a redirect. When the PC turns out to be illegal it is left
   // where it is so the faulting address stays visible on mem_addr. The fault
   // can only be cleared by a redirect or a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc  <= RESET_PC;
         faultReg <= 1'b0;
      end else if (redirect_valid) begin
         fetchPc  <= redirect_pc;
         faultReg <= 1'b0;
      end else begin
         if (pushEn) begin
            fetchPc <= fetchPc + 32'd4;
         end
         if (faultSet) begin
            faultReg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Prefetch FIFO pointers and occupancy
   // ------------------------------------------------------------------------

   // Pointers are exactly log2(depth) bits wide, so with a power-of-two depth
   // they wrap on their own. The occupancy counter carries the full/empty
   // distinction that the equal-pointer case cannot. A flush simply rewinds
   // both pointers; the stale storage behind them is never presented because
   // instr_valid is derived from the counter.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + ONE_PTR;
         end
         if (popEn) begin
            rdPtr <= rdPtr + ONE_PTR;
         end
         unique case ({pushEn, popEn})
            2'b10:   count <= count + ONE_LEVEL;
            2'b01:   count <= count - ONE_LEVEL;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Prefetch FIFO storage
   // ------------------------------------------------------------------------

   // Each entry keeps the fetched word together with the address it came
   // from so decode can see the PC of every instruction. Reset clears the
   // storage so the head outputs read zero straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pcBuf[i]   <= '0;
            dataBuf[i] <= '0;
         end
      end else if (pushEn) begin
         pcBuf[wrPtr]   <= fetchPc;
         dataBuf[wrPtr] <= mem_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------

   // All handshake outputs come straight from FIFO registers, so they hold
   // steady while the consumer stalls and nothing combinational from the
   // consumer side leaks into instr or instr_pc.
   always_comb begin
      mem_addr    = fetchPc;
      instr_valid = (count != '0);
      instr       = dataBuf[rdPtr];
      instr_pc    = pcBuf[rdPtr];
      fault       = faultReg;
      level       = count;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for instr_fetch_unit. A combinational instruction
// memory holds word[i] = 32'h1000_0000 + i. A queue-based reference model of
// the fetch unit predicts every output after every edge. A table of directed
// vectors with hand-derived expected outputs walks through streaming,
// backpressure, redirect, end-of-memory, misaligned redirect, reset and
// fetch-disable cases; a hand-written streaming run follows, then a long
// randomized run checked against the model.
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          MEM_WORDS  = 16;
   localparam int          FIFO_DEPTH = 2;
   localparam int          LVL_W      = $clog2(FIFO_DEPTH + 1);
   localparam int          RAND_CYCLES = 3000;

   logic             clk;
   logic             rst;
   logic             fetchEn;
   logic [31:0]      memAddr;
   logic [31:0]      memData;
   logic             instrValid;
   logic             instrReady;
   logic [31:0]      instr;
   logic [31:0]      instrPc;
   logic             redirectValid;
   logic [31:0]      redirectPc;
   logic             fault;
   logic [LVL_W-1:0] level;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetchEn),
      .mem_addr       (memAddr),
      .mem_data       (memData),
      .instr_valid    (instrValid),
      .instr_ready    (instrReady),
      .instr          (instr),
      .instr_pc       (instrPc),
      .redirect_valid (redirectValid),
      .redirect_pc    (redirectPc),
      .fault          (fault),
      .level          (level)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory contents; addresses outside memory return a marker
   // value that must never reach the FIFO.
   function automatic logic [31:0] wordAt(input logic [31:0] addr);
      if (addr < 32'(MEM_WORDS * 4)) begin
         return 32'h1000_0000 + (addr >> 2);
      end
      return 32'hDEAD_BEEF;
   endfunction

   // Combinational memory read.
   always_comb begin
      memData = wordAt(memAddr);
   end

   // ------------------------------------------------------------------------
   // Reference model: the prefetch buffer as a queue of {pc, word} pairs.
   // ------------------------------------------------------------------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   entry_t      modelQ[$];
   logic [31:0] modelPc;
   logic        modelFault;
   bit          modelJustReset;

   // Advance the model by one clock edge given the inputs held for that cycle.
   task automatic modelStep(input bit r, input bit en, input bit rdy,
                            input bit rv, input logic [31:0] rpc);
      bit     pop;
      bit     room;
      entry_t e;
      modelJustReset = 1'b0;
      if (r) begin
         modelQ.delete();
         modelPc        = RESET_PC;
         modelFault     = 1'b0;
         modelJustReset = 1'b1;
      end else if (rv) begin
         modelQ.delete();
         modelPc    = rpc;
         modelFault = 1'b0;
      end else begin
         pop  = (modelQ.size() > 0) && rdy;
         room = (modelQ.size() < FIFO_DEPTH) || pop;
         if (pop) begin
            void'(modelQ.pop_front());
         end
         if (en && !modelFault && room) begin
            if (modelPc[1:0] != 2'b00 || modelPc >= 32'(MEM_WORDS * 4)) begin
               modelFault = 1'b1;
            end else begin
               e.pc   = modelPc;
               e.data = wordAt(modelPc);
               modelQ.push_back(e);
               modelPc = modelPc + 32'd4;
            end
         end
      end
   endtask

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   task automatic compareVal(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Compare every DUT output against the reference model.
   task automatic checkOutput(input string name);
      compareVal({name, ".valid"}, 32'(instrValid), 32'(modelQ.size() > 0));
      compareVal({name, ".level"}, 32'(level), 32'(modelQ.size()));
      compareVal({name, ".addr"},  memAddr, modelPc);
      compareVal({name, ".fault"}, 32'(fault), 32'(modelFault));
      if (modelQ.size() > 0) begin
         compareVal({name, ".instr"}, instr, modelQ[0].data);
         compareVal({name, ".pc"},    instrPc, modelQ[0].pc);
      end else if (modelJustReset) begin
         compareVal({name, ".rstInstr"}, instr, 32'h0);
         compareVal({name, ".rstPc"},    instrPc, 32'h0);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model and
   // leave the outputs settled for sampling 1 unit after the edge.
   task automatic applyStimulus(input bit r, input bit en, input bit rdy,
                                input bit rv, input logic [31:0] rpc);
      rst           = r;
      fetchEn       = en;
      instrReady    = rdy;
      redirectValid = rv;
      redirectPc    = rpc;
      modelStep(r, en, rdy, rv, rpc);
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------------
   typedef struct {
      bit          r;
      bit          en;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          expValid;
      int          expLevel;
      logic [31:0] expAddr;
      bit          expFault;
      logic [31:0] expInstr;
      logic [31:0] expPc;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input bit r, input bit en, input bit rdy, input bit rv,
                         input logic [31:0] rpc, input bit ev, input int el,
                         input logic [31:0] ea, input bit ef,
                         input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.r = r; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.expValid = ev; v.expLevel = el; v.expAddr = ea; v.expFault = ef;
      v.expInstr = ei; v.expPc = ep;
      vecs.push_back(v);
   endtask

   task automatic checkVector(input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      compareVal({tag, ".valid"}, 32'(instrValid), 32'(vecs[idx].expValid));
      compareVal({tag, ".level"}, 32'(level), 32'(vecs[idx].expLevel));
      compareVal({tag, ".addr"},  memAddr, vecs[idx].expAddr);
      compareVal({tag, ".fault"}, 32'(fault), 32'(vecs[idx].expFault));
      if (vecs[idx].expValid) begin
         compareVal({tag, ".instr"}, instr, vecs[idx].expInstr);
         compareVal({tag, ".pc"},    instrPc, vecs[idx].expPc);
      end
   endtask

   initial begin
      bit          rr, ee, yy, vv;
      logic [31:0] pp;

      rst = 1'b1; fetchEn = 1'b0; instrReady = 1'b0;
      redirectValid = 1'b0; redirectPc = 32'h0;
      modelPc = RESET_PC; modelFault = 1'b0; modelJustReset = 1'b0;

      //     r  en rdy rv rpc       | valid lvl addr   flt instr          pc
      // Streaming
      addVec(1, 1, 1, 0, 32'h0,      0, 0, 32'h00, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h04, 0, 32'h1000_0000, 32'h00);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h08, 0, 32'h1000_0001, 32'h04);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h0C, 0, 32'h1000_0002, 32'h08);
      // Backpressure from reset, then release
      addVec(1, 1, 0, 0, 32'h0,      0, 0, 32'h00, 0, 32'h0,         32'h0);
      addVec(0, 1, 0, 0, 32'h0,      1, 1, 32'h04, 0, 32'h1000_0000, 32'h00);
      addVec(0, 1, 0, 0, 32'h0,      1, 2, 32'h08, 0, 32'h1000_0000, 32'h00);
      addVec(0, 1, 0, 0, 32'h0,      1, 2, 32'h08, 0, 32'h1000_0000, 32'h00);
      addVec(0, 1, 1, 0, 32'h0,      1, 2, 32'h0C, 0, 32'h1000_0001, 32'h04);
      addVec(0, 1, 1, 0, 32'h0,      1, 2, 32'h10, 0, 32'h1000_0002, 32'h08);
      // Redirect with a full FIFO
      addVec(0, 1, 1, 1, 32'h20,     0, 0, 32'h20, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h24, 0, 32'h1000_0008, 32'h20);
      // Misaligned redirect
      addVec(0, 1, 1, 1, 32'h22,     0, 0, 32'h22, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      0, 0, 32'h22, 1, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      0, 0, 32'h22, 1, 32'h0,         32'h0);
      // End of memory, then redirect back to 0
      addVec(0, 1, 1, 1, 32'h38,     0, 0, 32'h38, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h3C, 0, 32'h1000_000E, 32'h38);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h40, 0, 32'h1000_000F, 32'h3C);
      addVec(0, 1, 1, 0, 32'h0,      0, 0, 32'h40, 1, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      0, 0, 32'h40, 1, 32'h0,         32'h0);
      addVec(0, 1, 1, 1, 32'h0,      0, 0, 32'h00, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h04, 0, 32'h1000_0000, 32'h00);
      // Reset mid-stream with a full FIFO
      addVec(0, 1, 0, 0, 32'h0,      1, 2, 32'h08, 0, 32'h1000_0000, 32'h00);
      addVec(1, 1, 0, 0, 32'h0,      0, 0, 32'h00, 0, 32'h0,         32'h0);
      addVec(0, 1, 0, 0, 32'h0,      1, 1, 32'h04, 0, 32'h1000_0000, 32'h00);
      // fetch_en low: pops continue, PC holds
      addVec(0, 0, 1, 0, 32'h0,      0, 0, 32'h04, 0, 32'h0,         32'h0);
      addVec(0, 0, 1, 0, 32'h0,      0, 0, 32'h04, 0, 32'h0,         32'h0);
      addVec(0, 1, 1, 0, 32'h0,      1, 1, 32'h08, 0, 32'h1000_0001, 32'h04);

      $display("[TB] directed vectors: %0d", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].r, vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
         checkOutput("dirModel");
         checkVector(i);
      end

      // Hand-written full stream from reset through the end of memory:
      // every word appears exactly once in order, then the fetch faults.
      $display("[TB] full-memory stream");
      applyStimulus(1, 1, 1, 0, 32'h0);
      checkOutput("streamModel");
      for (int k = 1; k <= MEM_WORDS; k++) begin
         applyStimulus(0, 1, 1, 0, 32'h0);
         checkOutput("streamModel");
         compareVal($sformatf("stream%0d.valid", k), 32'(instrValid), 32'h1);
         compareVal($sformatf("stream%0d.pc", k), instrPc, 32'((k - 1) * 4));
         compareVal($sformatf("stream%0d.instr", k), instr,
                    32'h1000_0000 + 32'(k - 1));
      end
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("streamModel");
      compareVal("streamEnd.fault", 32'(fault), 32'h1);
      compareVal("streamEnd.valid", 32'(instrValid), 32'h0);
      compareVal("streamEnd.addr", memAddr, 32'h40);

      // Randomized run against the reference model.
      $display("[TB] random run: %0d cycles", RAND_CYCLES);
      for (int c = 0; c < RAND_CYCLES; c++) begin
         rr = ($urandom_range(0, 63) == 0);
         ee = ($urandom_range(0, 7) != 0);
         yy = ($urandom_range(0, 3) != 0);
         vv = ($urandom_range(0, 15) == 0);
         pp = 32'($urandom_range(0, 19)) << 2;
         if ($urandom_range(0, 7) == 0) begin
            pp = pp | 32'($urandom_range(1, 3));
         end
         if ($urandom_range(0, 31) == 0) begin
            pp = $urandom;
         end
         applyStimulus(rr, ee, yy, vv, pp);
         checkOutput("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives word addresses to the combinational instruction memory. Each returned word is captured into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_WORDS, 16, number of 32-bit words in instruction memory; legal byte addresses are 0 to MEM_WORDS*4-4.
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- fetch_en, input, 1, permits new fetches when high.
- mem_addr, output, 32, byte address to instruction memory; always equals fetch_pc.
- mem_data, input, 32, word from memory, valid in the same cycle as mem_addr (combinational read).
- instr_valid, output, 1, FIFO head holds an instruction.
- instr_ready, input, 1, consumer accepts the head.
- instr, output, 32, instruction word at FIFO head.
- instr_pc, output, 32, byte address the head was fetched from.
- redirect_valid, input, 1, flush and restart fetch at redirect_pc.
- redirect_pc, input, 32, new fetch address.
- fault, output, 1, sticky; fetch blocked on an illegal PC.
- level, output, $clog2(FIFO_DEPTH+1), current FIFO occupancy.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values: fetch_pc=RESET_PC, level=0, instr_valid=0, fault=0, instr=0, instr_pc=0.
- Fetch legality: fetch_ok = fetch_en && !fault && (FIFO not full, or a pop occurs this cycle).
- Illegal PC: fetch_pc[1:0]!=0, or fetch_pc >= MEM_WORDS*4.
  - If fetch_ok and the PC is illegal: no push, fault<=1, fetch_pc unchanged.
- Push: if fetch_ok and the PC is legal, write {fetch_pc, mem_data} to the FIFO tail and set fetch_pc<=fetch_pc+4. The addition is 32-bit modulo.
- Pop: occurs when instr_valid && instr_ready. The head advances.
- Handshake: instr, instr_pc and instr_valid come straight from FIFO head registers. They hold stable while instr_valid && !instr_ready.
- Simultaneous push and pop: allowed when full, level unchanged. Sustained throughput is 1 instruction per cycle.
- Latency: the word fetched in cycle N appears at the outputs with instr_valid=1 in cycle N+1. After rst deasserts, the first instr_valid is 1 cycle later (PC=RESET_PC).
- Redirect (highest priority):
  - In a cycle with redirect_valid=1: the FIFO is flushed (level<=0), fetch_pc<=redirect_pc, fault<=0, and no push.
  - Any handshake in that cycle is void; the consumer discards it.
  - The redirected instruction is pushed the next cycle and is valid 2 cycles after redirect.
  - A misaligned or out-of-range redirect_pc sets fault on the next fetch attempt.
- Fault:
  - Once set, no further fetches. Entries already in the FIFO still drain normally.
  - Cleared only by redirect_valid or rst.
- fetch_en=0: no push and no fault detection. Pops continue and fetch_pc holds.
- Reset mid-operation overrides everything: the FIFO is emptied, and outputs take their reset values on the next edge.
- Pointers: FIFO read/write pointers wrap modulo FIFO_DEPTH. level never exceeds FIFO_DEPTH.

Test Plan:
- Streaming: memory word[i]=32'h1000_0000+i, fetch_en=1, instr_ready=1, release rst.
  - Cycle 1: instr=32'h1000_0000, instr_pc=0.
  - Each following cycle: pc 4, 8, ..., one instruction per cycle, none skipped or duplicated.
- Backpressure: instr_ready=0 from cycle 1 → level reaches 2, mem_addr stalls at 32'h8, instr holds 32'h1000_0000. Then instr_ready=1 → sequence continues 0,4,8,... with no loss.
- Redirect with full FIFO: redirect_valid=1, redirect_pc=32'h20, instr_ready=1 → next cycle level=0, instr_valid=0, mem_addr=32'h20. Following cycle: instr_valid=1, instr_pc=32'h20, instr=32'h1000_0008.
- End of memory: run to pc 32'h3C → the 32'h3C instruction is delivered, then fault=1 with mem_addr=32'h40 and no further valid. Then redirect to 32'h0 → fault=0 and fetch resumes at 0.
- Misaligned redirect: redirect_pc=32'h22 → fault=1 one cycle later, instr_valid stays 0, level=0.
- Reset mid-stream: FIFO full, instr_ready=0, assert rst 1 cycle → instr_valid=0, level=0, mem_addr=RESET_PC, fault=0. The first instruction reappears 1 cycle after rst drops.
